// File: rtl/mer_pkg.sv
// rtl/mer_pkg.sv - packet layout and arbitration mode constants for the merger
package mer_pkg;

  localparam int PKT_W    = 64;
  localparam int LR_B     = 63;
  localparam int NODE_LSB = 47;
  localparam int GEN_LSB  = 35;
  localparam int OPR_LSB  = 3;
  localparam int UNI_B    = 2;
  localparam int WEN_LSB  = 0;

  localparam int NODE_W = LR_B - NODE_LSB;
  localparam int GEN_W  = NODE_LSB - GEN_LSB;
  localparam int OPR_W  = GEN_LSB - OPR_LSB;
  localparam int WEN_W  = UNI_B - WEN_LSB;

  localparam int MODE_RR  = 0;
  localparam int MODE_FIX = 1;

  typedef struct packed {
    logic              lr;
    logic [NODE_W-1:0] node;
    logic [GEN_W-1:0]  gen;
    logic [OPR_W-1:0]  opr;
    logic              uni_opr;
    logic [WEN_W-1:0]  mem_wen;
  } pkt_t;

endpackage

// File: rtl/mer_fifo.sv
// rtl/mer_fifo.sv - single-channel synchronous FIFO with head-of-queue output
module mer_fifo
  import mer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  pkt_t din,
  output pkt_t head,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  pkt_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  // Pointers wrap naturally; count carries the extra bit to tell full from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/mer_rr_n.sv
// rtl/mer_rr_n.sv - N-channel packet merger: per-channel FIFOs, RR/fixed arbiter, registered output
module mer_rr_n #(
  parameter int N_CH  = 4,
  parameter int DEPTH = 4,
  parameter int MODE  = mer_pkg::MODE_RR,
  parameter int PKT_W = mer_pkg::PKT_W,
  parameter int CH_W  = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       in_valid_i_mer,
  output logic [N_CH-1:0]       in_ready_o_mer,
  input  logic [N_CH*PKT_W-1:0] pkt_i_mer,
  output logic                  out_valid_o_mer,
  input  logic                  out_ready_i_mer,
  output logic [PKT_W-1:0]      pkt_o_mer,
  output logic [CH_W-1:0]       src_o_mer,
  output logic                  ovf_o_mer
);

  import mer_pkg::*;

  logic [N_CH-1:0] full;
  logic [N_CH-1:0] empty;
  logic [N_CH-1:0] push;
  logic [N_CH-1:0] pop;
  pkt_t            head [N_CH];
  logic [CH_W-1:0] ptr;
  logic [CH_W-1:0] grant;
  logic            any;
  logic            load;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    mer_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[c]),
      .pop   (pop[c]),
      .din   (pkt_t'(pkt_i_mer[c*PKT_W +: PKT_W])),
      .head  (head[c]),
      .full  (full[c]),
      .empty (empty[c])
    );
  end

  assign in_ready_o_mer = rst ? '0 : ~full;
  assign push           = in_valid_i_mer & in_ready_o_mer;
  assign load           = !out_valid_o_mer || out_ready_i_mer;
  assign any            = ~&empty;

  // Round-robin scans from ptr+1 with wrap; fixed priority scans from channel 0.
  always_comb begin
    int   idx;
    logic found;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= N_CH; i++) begin
      if (MODE == MODE_FIX) idx = i - 1;
      else begin
        idx = int'(ptr) + i;
        if (idx >= N_CH) idx = idx - N_CH;
      end
      if (!found && !empty[CH_W'(idx)]) begin
        grant = CH_W'(idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    pop = '0;
    if (load && any) pop[grant] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_o_mer <= 1'b0;
      pkt_o_mer       <= '0;
      src_o_mer       <= '0;
      ovf_o_mer       <= 1'b0;
      ptr             <= CH_W'(N_CH - 1);
    end else begin
      if (|(in_valid_i_mer & ~in_ready_o_mer)) ovf_o_mer <= 1'b1;
      if (load) begin
        out_valid_o_mer <= any;
        if (any) begin
          pkt_o_mer <= head[grant];
          src_o_mer <= grant;
          if (MODE == MODE_RR) ptr <= grant;
        end
      end
    end
  end

endmodule
